// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the IF fetch port and the MEM data port.
// Optional grant/conflict counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_STARVE  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]       stat_if_grants,
   output logic [31:0]       stat_dm_grants,
   output logic [31:0]       stat_conflicts
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);

   state_t            state;
   logic [3:0]        starve_cnt;
   logic [7:0]        tmo_cnt;
   logic              grant_i, grant_d, busy, finish;
   logic [DATA_W-1:0] cap_data;

   // Data port normally wins; the fetch port wins once it has lost MAX_STARVE times in a row.
   always_comb begin
      grant_i  = if_req & (~dm_req | (starve_cnt >= STARVE_LIM));
      grant_d  = dm_req & ~grant_i;
      busy     = (state == BUSY_I) | (state == BUSY_D);
      finish   = busy & (mem_ready | (tmo_cnt == TMO_LAST));
      // Stores and timeouts return zero; a ready in the timeout cycle still returns real data.
      cap_data = (mem_ready && !mem_we) ? mem_rdata : '0;
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         if_ack     <= 1'b0;
         dm_ack     <= 1'b0;
         err        <= 1'b0;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_i) begin
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  starve_cnt <= '0;
                  tmo_cnt    <= '0;
                  state      <= BUSY_I;
               end else if (grant_d) begin
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  tmo_cnt   <= '0;
                  if (if_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
                  state     <= BUSY_D;
               end
            end
            BUSY_I, BUSY_D: begin
               if (finish) begin
                  mem_req <= 1'b0;
                  state   <= DONE;
                  if (!mem_ready) err <= 1'b1;
                  if (state == BUSY_I) begin
                     if_rdata <= cap_data;
                     if_ack   <= 1'b1;
                  end else begin
                     dm_rdata <= cap_data;
                     dm_ack   <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         stat_if_grants <= '0;
         stat_dm_grants <= '0;
         stat_conflicts <= '0;
      end else if (state == IDLE) begin
         if (grant_i) stat_if_grants <= stat_if_grants + 32'd1;
         if (grant_d) stat_dm_grants <= stat_dm_grants + 32'd1;
         if (if_req && dm_req) stat_conflicts <= stat_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, starvation guard, timeout, async reset.
module tb_mem_port_arbiter;
   logic        clk = 1'b0, Reset = 1'b0;
   logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ack, dm_ack, mem_req, mem_we, mem_ready, stall_if, stall_mem, err;
   logic        rdy_en = 1'b0;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_grants, stat_dm_grants, stat_conflicts;
`endif

   int total = 0, bad = 0;
   int both_ack = 0;
   logic [31:0] glog[$];
   logic prev_req = 1'b0;

   always #5 clk = ~clk;

   // Memory model: ready whenever enabled, read data is a fixed function of the address.
   assign mem_ready = mem_req & rdy_en;
   assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .Reset(Reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
`ifdef MEM_ARB_STATS_EN
      , .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants),
      .stat_conflicts(stat_conflicts)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Grant log: the address of each new memory request.
   always @(posedge clk) begin
      #1;
      if (mem_req && !prev_req) glog.push_back(mem_addr);
      prev_req = mem_req;
      if (if_ack && dm_ack) both_ack++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] pat;
      int n;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_err", err, 0);
      chk("rst_acks", {if_ack, dm_ack}, 0);
      Reset  = 1'b1;
      rdy_en = 1'b1;

      // single fetch, minimum latency
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clk);
      chk("t1_mem_req", mem_req, 1);
      chk("t1_mem_addr", mem_addr, 32'h10);
      chk("t1_mem_we", mem_we, 0);
      chk("t1_stall", stall_if, 1);
      @(negedge clk);
      chk("t1_ack", if_ack, 1);
      chk("t1_rdata", if_rdata, 32'h5A5A_0010);
      chk("t1_nostall", stall_if, 0);
      if_req = 1'b0;
      @(negedge clk);
      chk("t1_ack_off", if_ack, 0);

      // conflict: store wins, then fetch
      if_req = 1'b1; if_addr = 32'h20;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("t2_we", mem_we, 1);
      chk("t2_addr", mem_addr, 32'h40);
      chk("t2_wdata", mem_wdata, 32'hCAFE_F00D);
      chk("t2_stall_if", stall_if, 1);
      @(negedge clk);
      chk("t2_dm_ack", dm_ack, 1);
      chk("t2_dm_rdata", dm_rdata, 0);
      chk("t2_if_ack", if_ack, 0);
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      chk("t2_stall_idle", stall_if, 1);
      chk("t2_req_idle", mem_req, 0);
      @(negedge clk);
      chk("t2_i_addr", mem_addr, 32'h20);
      chk("t2_i_we", mem_we, 0);
      @(negedge clk);
      chk("t2_if_ack", if_ack, 1);
      chk("t2_if_rdata", if_rdata, 32'h5A5A_0020);
      chk("t2_stall_off", stall_if, 0);
      if_req = 1'b0;

      @(negedge clk) Reset = 1'b0;
      @(negedge clk) Reset = 1'b1;

      // both ports requesting continuously: starvation guard
      glog.delete();
      if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0;
      if_req = 1'b1; dm_req = 1'b1;
      n = 0;
      while (glog.size() < 10 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if_req = 1'b0; dm_req = 1'b0;
      chk("t3_grants", glog.size(), 10);
      pat = '0;
      for (int i = 0; i < 10 && i < glog.size(); i++) pat[i] = (glog[i] == 32'h100);
      chk("t3_seq", pat, 10'h210);
      repeat (3) @(negedge clk);
`ifdef MEM_ARB_STATS_EN
      chk("t6_dm_grants", stat_dm_grants, 8);
      chk("t6_if_grants", stat_if_grants, 2);
      chk("t6_conflicts", stat_conflicts, 10);
`endif

      // ready arrives in the timeout cycle: ready wins
      rdy_en = 1'b0;
      dm_req = 1'b1; dm_addr = 32'h4C;
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("tie_busy", mem_req, 1);
      rdy_en = 1'b1;
      @(negedge clk);
      chk("tie_ack", dm_ack, 1);
      chk("tie_err", err, 0);
      chk("tie_rdata", dm_rdata, 32'h5A5A_004C);
      dm_req = 1'b0; rdy_en = 1'b0;
      @(negedge clk);

      // timeout
      dm_req = 1'b1; dm_addr = 32'h44;
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("t4_busy", mem_req, 1);
      chk("t4_noerr", err, 0);
      @(negedge clk);
      chk("t4_ack", dm_ack, 1);
      chk("t4_err", err, 1);
      chk("t4_rdata", dm_rdata, 0);
      chk("t4_req_off", mem_req, 0);
      dm_req = 1'b0;
      @(negedge clk);
      rdy_en = 1'b1;
      dm_req = 1'b1; dm_addr = 32'h48;
      repeat (2) @(negedge clk);
      chk("t4_ok_ack", dm_ack, 1);
      chk("t4_ok_rdata", dm_rdata, 32'h5A5A_0048);
      chk("t4_sticky", err, 1);
      dm_req = 1'b0;
      @(negedge clk);

      // async reset during a data access
      rdy_en = 1'b0;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234;
      @(negedge clk);
      chk("t5_busy", mem_req, 1);
      #1 Reset = 1'b0;
      #1;
      chk("t5_async_req", mem_req, 0);
      chk("t5_async_addr", mem_addr, 0);
      chk("t5_err_clr", err, 0);
      repeat (2) @(negedge clk);
      chk("t5_no_ack", dm_ack, 0);
      rdy_en = 1'b1;
      Reset  = 1'b1;
      @(negedge clk);
      chk("t5_req", mem_req, 1);
      chk("t5_addr", mem_addr, 32'h80);
      chk("t5_we", mem_we, 1);
      @(negedge clk);
      chk("t5_ack", dm_ack, 1);
      chk("t5_rdata", dm_rdata, 0);
      dm_req = 1'b0; dm_we = 1'b0;
      repeat (2) @(negedge clk);

      chk("ack_excl", both_ack, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
